// File: rtl/proc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : proc_control_fsm
// Description : Multi-cycle FETCH/DECODE/EXEC/WB control sequencer that
//               issues register-file and PC strobes and counts retirements.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_control_fsm #(
    parameter int              INS_W   = 8,
    parameter int              OP_W    = 2,
    parameter logic [OP_W-1:0] OPC_ADD = 2'b00,
    parameter logic [OP_W-1:0] OPC_LI  = 2'b01,
    parameter logic [OP_W-1:0] OPC_JMP = 2'b11,
    parameter int              RET_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INS_W-1:0] ins_code,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic             wb_ready,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             data_write,
    output logic             pc_src,
    output logic             pc_write,
    output logic             illegal,
    output logic             busy,
    output logic [RET_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t           r_state;
    logic [INS_W-1:0] r_ir;
    logic [RET_W-1:0] r_retired;

    logic [OP_W-1:0]  w_op;
    logic             w_is_add;
    logic             w_is_li;
    logic             w_is_jmp;
    logic             w_unused_ir_bits;

    assign w_op     = r_ir[INS_W-1 -: OP_W];
    assign w_is_add = (w_op == OPC_ADD);
    assign w_is_li  = (w_op == OPC_LI);
    assign w_is_jmp = (w_op == OPC_JMP);

    // Operand bits are carried in ir for the datapath but never steer control.
    assign w_unused_ir_bits = ^r_ir[INS_W-OP_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (ins_valid) begin
                        r_ir    <= ins_code;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_is_add || w_is_li) begin
                        r_state <= S_WB;
                    end else begin
                        if (w_is_jmp) begin
                            r_retired <= r_retired + RET_W'(1);
                        end
                        r_state <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        r_retired <= r_retired + RET_W'(1);
                        r_state   <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Strobes depend only on registered state/ir; in WB the write strobe
    // tracks wb_ready so a stall never produces a repeated write.
    always_comb begin
        ins_ready  = 1'b0;
        busy       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        data_write = 1'b0;
        pc_src     = 1'b0;
        pc_write   = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                ins_ready = ~rst;
            end
            S_DECODE: begin
                busy = 1'b1;
            end
            S_EXEC: begin
                busy = 1'b1;
                if (w_is_jmp) begin
                    pc_src   = 1'b1;
                    pc_write = 1'b1;
                end else if (!w_is_add && !w_is_li) begin
                    illegal = 1'b1;
                end
            end
            S_WB: begin
                busy       = 1'b1;
                reg_dst    = w_is_li;
                data_write = w_is_add;
                reg_write  = wb_ready;
                pc_write   = wb_ready;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign retired_cnt = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_proc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_control_fsm
// Description : Self-checking bench for proc_control_fsm (table-driven).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_control_fsm;

    logic        clk;
    logic        rst;
    logic [7:0]  ins_code;
    logic        ins_valid;
    logic        wb_ready;

    logic        ins_ready, reg_write, reg_dst, data_write, pc_src, pc_write, illegal, busy;
    logic [15:0] retired_cnt;

    logic        ins_ready2, reg_write2, reg_dst2, data_write2, pc_src2, pc_write2, illegal2, busy2;
    logic [1:0]  retired_cnt2;

    int n_pass  = 0;
    int n_total = 0;
    int exp_cnt = 0;

    proc_control_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .ins_code    (ins_code),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .wb_ready    (wb_ready),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .data_write  (data_write),
        .pc_src      (pc_src),
        .pc_write    (pc_write),
        .illegal     (illegal),
        .busy        (busy),
        .retired_cnt (retired_cnt)
    );

    // Narrow counter instance shares the stimulus to exercise wraparound.
    proc_control_fsm #(.RET_W(2)) dut_w2 (
        .clk         (clk),
        .rst         (rst),
        .ins_code    (ins_code),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready2),
        .wb_ready    (wb_ready),
        .reg_write   (reg_write2),
        .reg_dst     (reg_dst2),
        .data_write  (data_write2),
        .pc_src      (pc_src2),
        .pc_write    (pc_write2),
        .illegal     (illegal2),
        .busy        (busy2),
        .retired_cnt (retired_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] code;
        int         stall;
        int         kind;     // 0 = ADD/LI, 1 = JMP, 2 = illegal
        logic       exp_dst;
        logic       exp_dw;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_counts();
        chk("retired_cnt", 32'(retired_cnt), 32'(exp_cnt[15:0]));
        chk("retired_cnt_w2", 32'(retired_cnt2), 32'(exp_cnt[1:0]));
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        chk("fetch_ready", 32'(ins_ready), 1);
        chk("fetch_busy", 32'(busy), 0);
        ins_code  = v.code;
        ins_valid = 1'b1;
        @(negedge clk);
        // DECODE: offer a different instruction that must be ignored.
        ins_code = 8'hC3;
        chk("decode_busy_ready", {30'd0, busy, ins_ready}, 32'b10);
        chk("decode_strobes", {29'd0, pc_write, reg_write, illegal}, 0);
        @(negedge clk);
        // EXEC
        ins_valid = 1'b0;
        wb_ready  = (v.stall == 0);
        case (v.kind)
            1: begin
                chk("jmp_exec_pc", {30'd0, pc_src, pc_write}, 32'b11);
                chk("jmp_exec_regwr", 32'(reg_write), 0);
                exp_cnt++;
            end
            2: begin
                chk("ill_exec_illegal", 32'(illegal), 1);
                chk("ill_exec_strobes", {29'd0, pc_write, reg_write, pc_src}, 0);
            end
            default: begin
                chk("reg_exec_strobes", {29'd0, pc_write, reg_write, illegal}, 0);
            end
        endcase
        if (v.kind == 0) begin
            @(negedge clk);
            for (int i = 0; i < v.stall; i++) begin
                chk("wb_stall_hold", {28'd0, reg_dst, data_write, reg_write, pc_write},
                    {28'd0, v.exp_dst, v.exp_dw, 2'b00});
                @(negedge clk);
            end
            wb_ready = 1'b1;
            #1;
            chk("wb_write", {27'd0, reg_dst, data_write, reg_write, pc_write, pc_src},
                {27'd0, v.exp_dst, v.exp_dw, 3'b110});
            exp_cnt++;
        end
        @(negedge clk);
        chk("back_fetch", {29'd0, ins_ready, busy, illegal}, 32'b100);
        chk("back_fetch_strobes", {30'd0, reg_write, pc_write}, 0);
        chk_counts();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{code: 8'h05, stall: 0, kind: 0, exp_dst: 1'b0, exp_dw: 1'b1};
        vecs[1] = '{code: 8'h4A, stall: 5, kind: 0, exp_dst: 1'b1, exp_dw: 1'b0};
        vecs[2] = '{code: 8'hC3, stall: 0, kind: 1, exp_dst: 1'b0, exp_dw: 1'b0};
        vecs[3] = '{code: 8'h80, stall: 0, kind: 2, exp_dst: 1'b0, exp_dw: 1'b0};
        vecs[4] = '{code: 8'h3F, stall: 1, kind: 0, exp_dst: 1'b0, exp_dw: 1'b1};
        vecs[5] = '{code: 8'hBF, stall: 0, kind: 2, exp_dst: 1'b0, exp_dw: 1'b0};

        rst       = 1'b1;
        ins_code  = 8'h00;
        ins_valid = 1'b0;
        wb_ready  = 1'b1;

        @(negedge clk);
        chk("reset_outputs", {24'd0, ins_ready, busy, reg_write, reg_dst, data_write,
                              pc_src, pc_write, illegal}, 0);
        chk("reset_cnt", 32'(retired_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_ready_busy", {30'd0, ins_ready, busy}, 32'b10);
        chk_counts();

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k]);
        end

        // Reset in the middle of a stalled WB.
        @(negedge clk);
        ins_code  = 8'h4A;
        ins_valid = 1'b1;
        @(negedge clk);
        ins_valid = 1'b0;
        @(negedge clk);
        wb_ready = 1'b0;
        @(negedge clk);
        chk("midwb_in_wb", {30'd0, busy, reg_dst}, 32'b11);
        rst = 1'b1;
        #1;
        chk("midwb_rst_outputs", {24'd0, ins_ready, busy, reg_write, reg_dst, data_write,
                                  pc_src, pc_write, illegal}, 0);
        exp_cnt = 0;
        chk_counts();
        @(negedge clk);
        rst      = 1'b0;
        wb_ready = 1'b1;
        #1;
        chk("midwb_release", {29'd0, ins_ready, busy, reg_write}, 32'b100);
        @(negedge clk);
        chk("midwb_no_late_write", {30'd0, reg_write, pc_write}, 0);
        chk_counts();

        // Back-to-back ADDs: narrow counter wraps 3 -> 0.
        for (int k = 0; k < 4; k++) begin
            run_vec(vecs[0]);
        end
        chk("wrap_w2_zero", 32'(retired_cnt2), 0);
        chk("wrap_w16_four", 32'(retired_cnt), 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
